split6_stream_wn: RTL

//  - Receiver-side counterpart of the 6-lane combine macrocell: accepts one 6*inwidth packed word, emits lanes i0..i5 serially.
//  - Packing order is {i5,i4,i3,i2,i1,i0}: lane k = in_data[k*inwidth +: inwidth]; lane 0 is emitted first.
//  - Sits between a wide producer stage and a narrow consumer; valid/ready on both sides; 1-word holding register.

---
 rtl/split6_pkg.sv | 12 +
 rtl/split6_next_lane.sv | 27 ++
 rtl/split6_stream_wn.sv | 118 +++++++++++
 3 files changed

// File: rtl/split6_pkg.sv
// Shared constants and state encoding for the 6-lane stream splitter.
package split6_pkg;
  localparam int LANES  = 6;
  localparam int LANE_W = 3;
  localparam logic [LANES-1:0]  ALL_LANES = 6'b111111;
  localparam logic [LANE_W-1:0] LAST_LANE = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;
endpackage

// File: rtl/split6_next_lane.sv
// Priority encoder over a lane mask: next set lane above the current one,
// lowest set lane, and whether the current lane is the highest set lane.
module split6_next_lane
  import split6_pkg::*;
(
  input  logic [LANES-1:0]  mask,
  input  logic [LANE_W-1:0] lane,
  output logic [LANE_W-1:0] next_lane,
  output logic [LANE_W-1:0] first_lane,
  output logic              last
);
  always_comb begin
    next_lane  = lane;
    first_lane = '0;
    last       = 1'b1;
    // Descending scan so the lowest qualifying lane is written last and wins.
    for (int k = LANES - 1; k >= 0; k--) begin
      if (mask[k]) begin
        first_lane = LANE_W'(k);
        if (LANE_W'(k) > lane) begin
          next_lane = LANE_W'(k);
          last      = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/split6_stream_wn.sv
// Splits one 6-lane packed word {i5..i0} into serial lane words, lane 0 first.
// Optional lane skipping is enabled with the macro SPLIT6_STREAM_LANE_MASK_EN.
module split6_stream_wn
  import split6_pkg::*;
#(
  parameter int inwidth = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*inwidth-1:0] in_data,
`ifdef SPLIT6_STREAM_LANE_MASK_EN
  input  logic [LANES-1:0]         in_mask,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [inwidth-1:0]       out_data,
  output logic [LANE_W-1:0]        out_lane,
  output logic                     out_last
);
  state_t                   state_reg;
  logic [LANE_W-1:0]        lane_reg;
  logic [LANES*inwidth-1:0] hold_reg;
  logic [inwidth-1:0]       lanes [LANES];

  logic [LANE_W-1:0] next_lane;
  logic [LANE_W-1:0] load_first;
  logic              cur_last;
  logic              load_nonzero;
  logic              accept;

`ifdef SPLIT6_STREAM_LANE_MASK_EN
  logic [LANES-1:0]  mask_reg;
  logic [LANE_W-1:0] cur_first_unused;
  logic [LANE_W-1:0] load_next_unused;
  logic              load_last_unused;

  split6_next_lane u_cur (
    .mask       (mask_reg),
    .lane       (lane_reg),
    .next_lane  (next_lane),
    .first_lane (cur_first_unused),
    .last       (cur_last)
  );

  // The first lane of an incoming word comes from its own mask, not the held one.
  split6_next_lane u_load (
    .mask       (in_mask),
    .lane       (3'd0),
    .next_lane  (load_next_unused),
    .first_lane (load_first),
    .last       (load_last_unused)
  );

  assign load_nonzero = |in_mask;
`else
  assign next_lane    = lane_reg + 3'd1;
  assign load_first   = '0;
  assign cur_last     = (lane_reg == LAST_LANE);
  assign load_nonzero = 1'b1;
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lanes[gi] = hold_reg[gi*inwidth +: inwidth];
  end

  assign out_valid = (state_reg == EMIT);
  assign out_data  = out_valid ? lanes[lane_reg] : '0;
  assign out_lane  = lane_reg;
  assign out_last  = out_valid & cur_last;
  assign in_ready  = (state_reg == IDLE) | (out_valid & out_ready & cur_last);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lane_reg  <= '0;
      hold_reg  <= '0;
`ifdef SPLIT6_STREAM_LANE_MASK_EN
      mask_reg  <= '0;
`endif
    end else begin
      if (accept) begin
        hold_reg <= in_data;
`ifdef SPLIT6_STREAM_LANE_MASK_EN
        mask_reg <= in_mask;
`endif
      end
      case (state_reg)
        IDLE: begin
          if (in_valid && load_nonzero) begin
            state_reg <= EMIT;
            lane_reg  <= load_first;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (cur_last) begin
              if (in_valid && load_nonzero) begin
                lane_reg <= load_first;
              end else begin
                state_reg <= IDLE;
                lane_reg  <= '0;
              end
            end else begin
              lane_reg <= next_lane;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          lane_reg  <= '0;
        end
      endcase
    end
  end
endmodule
